// File: rtl/uart_recv.sv
// 8N1 UART receiver: synchronises the rx line, deframes characters at mid-bit
// and emits one-cycle valid / frame_err pulses alongside the received byte.
module uart_recv #(
    parameter int unsigned BAUD_CNT_MAX = 10416,
    parameter int unsigned SAMPLE_POINT = BAUD_CNT_MAX / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e              state_q;
    logic                rx_s1_q;
    logic                rx_s2_q;
    logic                rx_d_q;
    logic [CNT_W-1:0]    baud_cnt_q;
    logic [BIT_W-1:0]    bit_cnt_q;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   data_q;
    logic                valid_q;
    logic                frame_err_q;
    logic                busy_q;

    logic                start_edge;
    logic                at_sample;
    logic                at_max;

    assign start_edge = rx_d_q & ~rx_s2_q;
    assign at_sample  = (baud_cnt_q == CNT_W'(SAMPLE_POINT));
    assign at_max     = (baud_cnt_q == CNT_W'(BAUD_CNT_MAX));

    // Synchroniser, bit timing, deframing and registered pulse outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_d_q      <= 1'b1;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_s1_q     <= rx;
            rx_s2_q     <= rx_s1_q;
            rx_d_q      <= rx_s2_q;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    baud_cnt_q <= '0;
                    if (start_edge) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (at_sample && rx_s2_q) begin
                        // Line back high at mid-start: a glitch, not a character.
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        baud_cnt_q <= '0;
                    end else if (at_max) begin
                        state_q    <= DATA;
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (at_sample) begin
                        shift_q[bit_cnt_q] <= rx_s2_q;
                    end
                    if (at_max) begin
                        baud_cnt_q <= '0;
                        if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                            state_q <= STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    // Leave at mid-stop so a following start edge is never missed.
                    if (at_sample) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        baud_cnt_q <= '0;
                        if (rx_s2_q) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    baud_cnt_q <= '0;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule
